crypto_job_arbiter: RTL and testbench
=====================================

# crypto_job_arbiter

Shares one `crypto_accelerator_top` instance between `NUM_REQ` requester streams. Requesters submit jobs, each a counted run of blocks. The arbiter grants whole jobs in round-robin order and steers the granted requester's blocks into the accelerator. Because the accelerator returns blocks in input order, a job-owner FIFO lets the arbiter route each returning block back to the requester that owns it.

## Interface
- `BLOCK_WIDTH`, 32, block width; must match the accelerator.
- `NUM_REQ`, 4, number of requesters, 2..8.
- `LEN_WIDTH`, 8, width of the job-length field.
- `JOB_DEPTH`, 4, owner-FIFO depth, i.e. the maximum number of jobs in flight (power of 2).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in `NUM_REQ`: requester i has a job pending.
- `req_len` in `NUM_REQ*LEN_WIDTH`: job length for requester i, slice i. Value 0 encodes 2^LEN_WIDTH blocks.
- `req_grant` out `NUM_REQ`: one-cycle pulse when requester i's job is accepted.
- `req_data` in `NUM_REQ*BLOCK_WIDTH`: input blocks per requester.
- `req_data_valid` in `NUM_REQ`; `req_data_ready` out `NUM_REQ`.
- `acc_data_in` out `BLOCK_WIDTH`; `acc_data_in_valid` out 1; `acc_data_in_ready` in 1: connect to the accelerator input.
- `acc_data_out` in `BLOCK_WIDTH`; `acc_data_out_valid` in 1; `acc_data_out_ready` out 1: connect to the accelerator output.
- `rsp_data` out `BLOCK_WIDTH`: shared response data bus.
- `rsp_valid` out `NUM_REQ`; `rsp_ready` in `NUM_REQ`.
- `rsp_last` out 1: current response block is the last of its job.
- `busy` out 1: input FSM not in IDLE, or owner FIFO non-empty.

## Operation
- **Input FSM states:** IDLE, STREAM.
- **IDLE:**
  - Accepts a job when any `req_valid` is set and the owner FIFO is not full.
  - Selects the first requester with `req_valid` set, scanning upward from `rr_ptr` and wrapping.
  - On the next edge it:
    - registers the owner;
    - loads `in_cnt` with the length (width `LEN_WIDTH+1`; 0 becomes 2^LEN_WIDTH);
    - pushes {owner, length} into the owner FIFO;
    - sets `rr_ptr` to owner+1 mod `NUM_REQ`;
    - asserts `req_grant[owner]` for exactly that cycle;
    - enters STREAM.
- **STREAM:**
  - `acc_data_in` = `req_data[owner]`.
  - `acc_data_in_valid` = `req_data_valid[owner]`.
  - `req_data_ready[owner]` = `acc_data_in_ready`; every other `req_data_ready` is 0.
  - Each accelerator-input handshake decrements `in_cnt`. The handshake with `in_cnt`==1 returns the FSM to IDLE.
  - `req_valid` and `req_len` are ignored while in STREAM.
- **Output routing:**
  - While the owner FIFO is non-empty, with head {h_owner, h_len}:
    - `rsp_data` = `acc_data_out`;
    - `rsp_valid[h_owner]` = `acc_data_out_valid`;
    - `acc_data_out_ready` = `rsp_ready[h_owner]`.
  - `out_cnt` is loaded from h_len and counts response handshakes. `rsp_last` = `acc_data_out_valid` and (`out_cnt`==1).
  - The last handshake pops the FIFO; `out_cnt` reloads from the new head.
  - While the FIFO is empty, `acc_data_out_ready` = 0 and all `rsp_valid` = 0.
- **Simultaneous push and pop:** allowed. Occupancy is unchanged, and the full/empty flags are updated from the net count.
- **Full FIFO:** IDLE holds and no grant is issued. Arbitration resumes the cycle after a pop makes room.
- **Reset:**
  - State IDLE, `rr_ptr` 0, FIFO empty, both counters 0.
  - All outputs are 0: `req_grant`, `req_data_ready`, `acc_data_in_valid`, `acc_data_out_ready`, `rsp_valid`, `rsp_last`, `busy`; data buses 0.
  - A reset asserted mid-job discards all jobs in flight. The accelerator shares `rst_n`, so its pipeline is flushed at the same time.

## Timing
- **Job overhead:** one arbitration cycle (IDLE) per job.
- **First block of a job:** can transfer in the same cycle as `req_grant`.
- **Throughput:** sustained one block/cycle within a job. A job of N blocks therefore occupies the input for N+1 cycles when fully streaming.
- **Combinational paths:** data, valid and ready are passed through combinationally in both directions. The only added latency is the job arbitration cycle.
- **Back-pressure:** a stalled responder (`rsp_ready` low) stalls the accelerator output only. The input keeps accepting blocks until the accelerator itself deasserts `acc_data_in_ready`.
- **Registered outputs:** `req_grant` and `busy` are registered.
- **Fairness:** a requester with a pending job is granted within `NUM_REQ`-1 jobs of other requesters.

## Test plan
- **Single job:**
  - Stimulus: reset; req0 len=3, blocks 0xA1, 0xA2, 0xA3; responder always ready.
  - Required: `req_grant[0]` is a single pulse; `rsp_valid[0]` carries the three encrypted blocks in order; `rsp_last` is high on the 3rd; `busy` returns to 0 afterwards.
- **Round-robin:**
  - Stimulus: req0, req1 and req3 all valid with len=2, held.
  - Required: grant order 0, 1, 3, 0, 1, 3. Each response block appears only on its owner's `rsp_valid`.
- **FIFO full (`JOB_DEPTH`=4):**
  - Stimulus: `rsp_ready` held at 0; submit 5 jobs of len=1.
  - Required: exactly 4 grants, then no 5th grant. Raising `rsp_ready[owner0]` pops one entry, and the 5th grant follows one cycle later.
- **len=0:**
  - Stimulus: a job with `req_len`=0 and `LEN_WIDTH`=8.
  - Required: exactly 256 blocks are accepted and returned; `rsp_last` asserts only on block 256.
- **Back-pressure:**
  - Stimulus: a len=4 job with random `acc_data_in_ready` and `rsp_ready` toggling.
  - Required: no block is lost or duplicated, and `in_cnt` and `out_cnt` both reach 0.
- **Reset mid-job:**
  - Stimulus: assert `rst_n` low for 1 cycle after 2 of 5 blocks.
  - Required: all outputs are 0 immediately (asynchronously). After release, a new req2 len=1 job is granted and completes normally.

Source files
------------

// File: rtl/crypto_job_arbiter_if.sv
// Requester, accelerator and responder signals around crypto_job_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface crypto_job_arbiter_if #(
    parameter int unsigned BLOCK_WIDTH = 32,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned LEN_WIDTH   = 8
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*LEN_WIDTH-1:0]   req_len;
    logic [NUM_REQ-1:0]             req_grant;
    logic [NUM_REQ*BLOCK_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_data_valid;
    logic [NUM_REQ-1:0]             req_data_ready;
    logic [BLOCK_WIDTH-1:0]         acc_data_in;
    logic                           acc_data_in_valid;
    logic                           acc_data_in_ready;
    logic [BLOCK_WIDTH-1:0]         acc_data_out;
    logic                           acc_data_out_valid;
    logic                           acc_data_out_ready;
    logic [BLOCK_WIDTH-1:0]         rsp_data;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0]             rsp_ready;
    logic                           rsp_last;
    logic                           busy;

    modport slave (
        input  req_valid, req_len, req_data, req_data_valid,
               acc_data_in_ready, acc_data_out, acc_data_out_valid, rsp_ready,
        output req_grant, req_data_ready, acc_data_in, acc_data_in_valid,
               acc_data_out_ready, rsp_data, rsp_valid, rsp_last, busy
    );

    modport master (
        output req_valid, req_len, req_data, req_data_valid,
               acc_data_in_ready, acc_data_out, acc_data_out_valid, rsp_ready,
        input  req_grant, req_data_ready, acc_data_in, acc_data_in_valid,
               acc_data_out_ready, rsp_data, rsp_valid, rsp_last, busy
    );
endinterface

// File: rtl/crypto_job_arbiter.sv
// Round-robin job arbiter sharing one crypto accelerator between NUM_REQ requesters.
// An owner FIFO remembers job order so in-order accelerator output can be routed back.
module crypto_job_arbiter #(
    parameter int unsigned BLOCK_WIDTH = 32,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned JOB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    crypto_job_arbiter_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = LEN_WIDTH + 1;
    localparam int unsigned PTR_W = $clog2(JOB_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic {IDLE, STREAM} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [IDX_W-1:0]     fifo_owner_q [JOB_DEPTH];
    logic [IDX_W-1:0]     fifo_owner_d [JOB_DEPTH];
    logic [CNT_W-1:0]     fifo_len_q   [JOB_DEPTH];
    logic [CNT_W-1:0]     fifo_len_d   [JOB_DEPTH];

    int unsigned          cand;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [LEN_WIDTH-1:0] sel_len;
    logic [CNT_W-1:0]     push_len;
    logic                 fifo_full, fifo_ne, accept, in_hs, out_hs, pop;
    logic [IDX_W-1:0]     h_owner;
    logic [PTR_W-1:0]     rd_nxt;

    // First pending requester at or above rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!sel_found && bus.req_valid[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
        sel_len  = bus.req_len[sel_idx*LEN_WIDTH +: LEN_WIDTH];
        push_len = (sel_len == '0) ? (CNT_W'(1) << LEN_WIDTH) : {1'b0, sel_len};
    end

    assign fifo_full = (occ_q == OCC_W'(JOB_DEPTH));
    assign fifo_ne   = (occ_q != '0);
    assign h_owner   = fifo_owner_q[rd_ptr_q];
    assign rd_nxt    = rd_ptr_q + PTR_W'(1);
    assign accept    = (state_q == IDLE) && sel_found && !fifo_full;
    assign in_hs     = (state_q == STREAM) && bus.req_data_valid[owner_q] && bus.acc_data_in_ready;
    assign out_hs    = fifo_ne && bus.acc_data_out_valid && bus.rsp_ready[h_owner];
    assign pop       = out_hs && (out_cnt_q == CNT_W'(1));

    // Combinational steering of both data directions.
    always_comb begin
        bus.acc_data_in        = '0;
        bus.acc_data_in_valid  = 1'b0;
        bus.req_data_ready     = '0;
        bus.rsp_data           = '0;
        bus.rsp_valid          = '0;
        bus.acc_data_out_ready = 1'b0;
        bus.rsp_last           = 1'b0;
        if (state_q == STREAM) begin
            bus.acc_data_in             = bus.req_data[owner_q*BLOCK_WIDTH +: BLOCK_WIDTH];
            bus.acc_data_in_valid       = bus.req_data_valid[owner_q];
            bus.req_data_ready[owner_q] = bus.acc_data_in_ready;
        end
        if (fifo_ne) begin
            bus.rsp_data           = bus.acc_data_out;
            bus.rsp_valid[h_owner] = bus.acc_data_out_valid;
            bus.acc_data_out_ready = bus.rsp_ready[h_owner];
            bus.rsp_last           = bus.acc_data_out_valid && (out_cnt_q == CNT_W'(1));
        end
    end

    assign bus.req_grant = grant_q;
    assign bus.busy      = busy_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        grant_d      = '0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        fifo_owner_d = fifo_owner_q;
        fifo_len_d   = fifo_len_q;

        if (accept) begin
            state_d                = STREAM;
            owner_d                = sel_idx;
            in_cnt_d               = push_len;
            rr_ptr_d               = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
            grant_d[sel_idx]       = 1'b1;
            fifo_owner_d[wr_ptr_q] = sel_idx;
            fifo_len_d[wr_ptr_q]   = push_len;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end else if (in_hs) begin
            in_cnt_d = in_cnt_q - CNT_W'(1);
            if (in_cnt_q == CNT_W'(1)) state_d = IDLE;
        end

        if (pop) rd_ptr_d = rd_nxt;
        if (accept && !pop)      occ_d = occ_q + OCC_W'(1);
        else if (!accept && pop) occ_d = occ_q - OCC_W'(1);

        // out_cnt always tracks the remaining blocks of the FIFO head job.
        if (pop) begin
            if (occ_q > OCC_W'(1)) out_cnt_d = fifo_len_q[rd_nxt];
            else if (accept)       out_cnt_d = push_len;
            else                   out_cnt_d = '0;
        end else if (out_hs) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end else if (!fifo_ne && accept) begin
            out_cnt_d = push_len;
        end

        busy_d = (state_d != IDLE) || (occ_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            for (int unsigned i = 0; i < JOB_DEPTH; i++) begin
                fifo_owner_q[i] <= '0;
                fifo_len_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            fifo_owner_q <= fifo_owner_d;
            fifo_len_q   <= fifo_len_d;
        end
    end
endmodule

// File: tb/tb_crypto_job_arbiter.sv
// Directed bench for crypto_job_arbiter with a stand-in accelerator (XOR with KEY,
// one-cycle latency) and an ordered scoreboard of expected responses.
module tb_crypto_job_arbiter;
    localparam int unsigned BW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned LW = 8;
    localparam int unsigned JD = 4;
    localparam int unsigned IW = 2;
    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    typedef struct packed {
        logic [IW-1:0] owner;
        logic [31:0]   data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crypto_job_arbiter_if #(.BLOCK_WIDTH(BW), .NUM_REQ(NR), .LEN_WIDTH(LW)) bus ();
    crypto_job_arbiter #(.BLOCK_WIDTH(BW), .NUM_REQ(NR), .LEN_WIDTH(LW), .JOB_DEPTH(JD))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t        exp_q[$];
    logic [31:0] acc_q[$];
    int          grant_log[$];
    int          job_len  [NR][64];
    int          job_wr   [NR];
    int          job_rd   [NR];
    logic [31:0] src_data [NR][512];
    int          src_wr   [NR];
    int          src_rd   [NR];
    int          grant_cnt[NR];
    int          rsp_cnt, cyc, last_grant_cyc, last_out_cyc, first_in_cyc;
    bit          rand_acc, rand_rsp;
    logic [NR-1:0] rsp_mask;
    int          n_checks = 0;
    int          n_err = 0;

    bit          s_in_hs, s_out_hs;
    int          s_in_own;
    logic [31:0] s_in_data;
    logic [NR-1:0] s_grant;
    exp_t        e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        acc_q.delete();
        grant_log.delete();
        for (int i = 0; i < NR; i++) begin
            job_wr[i] = 0; job_rd[i] = 0; src_wr[i] = 0; src_rd[i] = 0; grant_cnt[i] = 0;
        end
        rsp_cnt = 0; last_grant_cyc = -1; last_out_cyc = -1; first_in_cyc = -1;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]      = job_rd[i] < job_wr[i];
            bus.req_len[i*LW +: LW] = (job_rd[i] < job_wr[i]) ? LW'(job_len[i][job_rd[i]]) : '0;
            bus.req_data_valid[i] = src_rd[i] < src_wr[i];
            bus.req_data[i*BW +: BW] = (src_rd[i] < src_wr[i]) ? src_data[i][src_rd[i]] : '0;
        end
        bus.acc_data_in_ready  = rand_acc ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.rsp_ready          = rand_rsp ? NR'($urandom_range(0, 15)) : rsp_mask;
        bus.acc_data_out_valid = acc_q.size() > 0;
        bus.acc_data_out       = (acc_q.size() > 0) ? acc_q[0] : '0;
    endtask

    task automatic submit(input int r, input int len, input logic [31:0] base);
        int n;
        exp_t x;
        n = (len == 0) ? (1 << LW) : len;
        job_len[r][job_wr[r]] = len;
        job_wr[r]++;
        for (int b = 0; b < n; b++) begin
            src_data[r][src_wr[r]] = base + 32'(b);
            src_wr[r]++;
            x.owner = IW'(r);
            x.data  = (base + 32'(b)) ^ KEY;
            x.last  = (b == n - 1);
            exp_q.push_back(x);
        end
    endtask

    function automatic int total_grants();
        int s = 0;
        for (int i = 0; i < NR; i++) s += grant_cnt[i];
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},      bus.req_grant, '0);
        check({tag, "_data_ready"}, bus.req_data_ready, '0);
        check({tag, "_in_valid"},   bus.acc_data_in_valid, '0);
        check({tag, "_in_data"},    bus.acc_data_in, '0);
        check({tag, "_out_ready"},  bus.acc_data_out_ready, '0);
        check({tag, "_rsp_valid"},  bus.rsp_valid, '0);
        check({tag, "_rsp_data"},   bus.rsp_data, '0);
        check({tag, "_rsp_last"},   bus.rsp_last, '0);
        check({tag, "_busy"},       bus.busy, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        clear_model();
        drive();
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit done = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk); #1;
            done = (exp_q.size() == 0) && (bus.busy == 1'b0);
            for (int i = 0; i < NR; i++) if (job_rd[i] != job_wr[i]) done = 1'b0;
            if (done) break;
        end
        check({tag, "_completed"}, done, 1'b1);
    endtask

    // Sample handshakes on the falling edge; apply them and re-drive after the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            s_in_hs = 1'b0; s_out_hs = 1'b0; s_grant = '0; s_in_own = 0;
            if (rst_n) begin
                s_grant = bus.req_grant;
                if (s_grant != '0) begin
                    check("grant_onehot", $countones(s_grant), 1);
                    last_grant_cyc = cyc;
                end
                if (bus.acc_data_in_valid && bus.acc_data_in_ready) begin
                    s_in_hs   = 1'b1;
                    s_in_data = bus.acc_data_in;
                    if (first_in_cyc < 0) first_in_cyc = cyc;
                    check("in_ready_onehot", $countones(bus.req_data_ready & bus.req_data_valid), 1);
                    for (int i = 0; i < NR; i++) if (bus.req_data_ready[i]) s_in_own = i;
                    check("in_data", bus.acc_data_in, src_data[s_in_own][src_rd[s_in_own]]);
                end
                if (bus.acc_data_out_valid && bus.acc_data_out_ready) begin
                    s_out_hs = 1'b1;
                    last_out_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        rsp_cnt++;
                        check("rsp_valid_owner", bus.rsp_valid, NR'(1) << e.owner);
                        check("rsp_data", bus.rsp_data, e.data);
                        check("rsp_last", bus.rsp_last, e.last);
                    end
                end
            end
            @(posedge clk); #1;
            if (rst_n) begin
                if (s_out_hs) void'(acc_q.pop_front());
                if (s_in_hs) begin
                    src_rd[s_in_own]++;
                    acc_q.push_back(s_in_data ^ KEY);
                end
                for (int i = 0; i < NR; i++) begin
                    if (s_grant[i]) begin
                        grant_cnt[i]++;
                        grant_log.push_back(i);
                        job_rd[i]++;
                    end
                end
            end
            drive();
        end
    end

    initial begin
        int exp_order[6];
        bit ok;
        exp_order = '{0, 1, 3, 0, 1, 3};
        rsp_mask = '1; rand_acc = 1'b0; rand_rsp = 1'b0; cyc = 0;
        clear_model();
        drive();
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single job of three blocks.
        submit(0, 3, 32'hA1);
        wait_done("single", 50);
        check("single_grants", grant_cnt[0], 1);
        check("single_rsp_cnt", rsp_cnt, 3);
        check("single_first_block_with_grant", first_in_cyc, last_grant_cyc);
        check("single_busy_idle", bus.busy, 1'b0);

        // Round-robin among requesters 0, 1 and 3.
        do_reset();
        submit(0, 2, 32'h100); submit(1, 2, 32'h200); submit(3, 2, 32'h300);
        submit(0, 2, 32'h110); submit(1, 2, 32'h210); submit(3, 2, 32'h310);
        wait_done("rr", 100);
        check("rr_grant_count", grant_log.size(), 6);
        if (grant_log.size() == 6)
            for (int k = 0; k < 6; k++) check("rr_grant_order", grant_log[k], exp_order[k]);

        // Owner FIFO fills at JOB_DEPTH jobs while responses are stalled.
        do_reset();
        rsp_mask = '0;
        submit(0, 1, 32'h400); submit(1, 1, 32'h410); submit(2, 1, 32'h420);
        submit(3, 1, 32'h430); submit(0, 1, 32'h440);
        repeat (20) @(negedge clk);
        #1;
        check("full_grants_held", total_grants(), 4);
        check("full_busy", bus.busy, 1'b1);
        rsp_mask = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (total_grants() == 5) begin ok = 1'b1; break; end
        end
        check("full_fifth_grant", ok, 1'b1);
        check("full_grant_after_pop", last_grant_cyc - last_out_cyc, 2);
        check("full_one_rsp", rsp_cnt, 1);
        rsp_mask = '1;
        wait_done("full_drain", 50);
        check("full_rsp_cnt", rsp_cnt, 5);

        // Length 0 encodes 256 blocks.
        do_reset();
        submit(2, 0, 32'h1000);
        wait_done("len0", 600);
        check("len0_rsp_cnt", rsp_cnt, 256);
        check("len0_accepted", src_rd[2], 256);
        check("len0_grants", grant_cnt[2], 1);

        // Random back-pressure on both sides.
        do_reset();
        rand_acc = 1'b1; rand_rsp = 1'b1;
        submit(1, 4, 32'hB0);
        submit(3, 4, 32'hB8);
        wait_done("bp", 300);
        rand_acc = 1'b0; rand_rsp = 1'b0;
        check("bp_rsp_cnt", rsp_cnt, 8);
        check("bp_accepted_r1", src_rd[1], 4);
        check("bp_accepted_r3", src_rd[3], 4);

        // Reset in the middle of a five-block job.
        do_reset();
        submit(1, 5, 32'hC0);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #2;
            if (src_rd[1] == 2) begin ok = 1'b1; break; end
        end
        check("mid_progress", ok, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        clear_model();
        drive();
        @(posedge clk); #3;
        rst_n = 1'b1;
        submit(2, 1, 32'hD0);
        wait_done("post_reset", 50);
        check("post_reset_grant", grant_cnt[2], 1);
        check("post_reset_no_old_grant", grant_cnt[1], 0);
        check("post_reset_rsp_cnt", rsp_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
